mem_fetch_stream: RTL and testbench

Sequential reader for the Mem4K port B. On start it walks memory word by word from a base address until it reads the sentinel word, and streams each {address, word} pair downstream on a valid/ready interface. It is the consumer-side counterpart of the program loader that fills memory through port A, and is the front end of the future instruction fetch path. A 2-entry buffer absorbs downstream backpressure, so port B is read at most once per address.

---
 rtl/mem_fetch_stream_pkg.sv | 27 ++
 rtl/mem_fetch_stream_if.sv | 23 ++
 rtl/mem_fetch_stream_skid2.sv | 72 +++++++
 rtl/mem_fetch_stream.sv | 126 ++++++++++++
 tb/tb_mem_fetch_stream.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/mem_fetch_stream_pkg.sv
// Shared definitions for the Mem4K port-B fetch streamer: bus encodings,
// memory limits, the sentinel word and the FSM state type.
package mem_fetch_stream_pkg;

    // Port enable / access size encodings shared with Mem4K
    localparam logic       MM_ENB_R = 1'b0;
    localparam logic       MM_ENB_W = 1'b1;
    localparam logic [1:0] MW_Byte  = 2'b00;
    localparam logic [1:0] MW_Half  = 2'b01;
    localparam logic [1:0] MW_Word  = 2'b10;

    localparam logic [31:0] SENTINEL   = 32'h0000FFFF;
    localparam logic [31:0] ADDR_LIMIT = 32'd4096;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // A base address is usable when word aligned and inside Mem4K
    function automatic logic base_ok(input logic [31:0] a);
        return (a[1:0] == 2'b00) && (a < ADDR_LIMIT);
    endfunction

endpackage

// File: rtl/mem_fetch_stream_if.sv
// Port-B memory bus plus the downstream valid/ready stream, bundled so the
// fetcher and its consumer/memory model connect through one port.
interface mem_fetch_stream_if;
    logic        B_EnWR;
    logic [1:0]  B_Size;
    logic [31:0] B_ABus;
    logic [31:0] B_DBusW;
    logic [31:0] B_DBusR;
    logic        o_valid;
    logic        o_ready;
    logic [31:0] o_data;
    logic [31:0] o_addr;

    modport master (
        output B_EnWR, B_Size, B_ABus, B_DBusW, o_valid, o_data, o_addr,
        input  B_DBusR, o_ready
    );

    modport slave (
        input  B_EnWR, B_Size, B_ABus, B_DBusW, o_valid, o_data, o_addr,
        output B_DBusR, o_ready
    );
endinterface

// File: rtl/mem_fetch_stream_skid2.sv
// Two-entry FIFO between the port-B read and the downstream consumer.
// Entry 0 is always the head; a pop when full shifts entry 1 forward.
module fetch_skid2 #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         valid,
    output logic [1:0]   occ
);

    logic [W-1:0] e0_q, e0_d, e1_q, e1_d;
    logic [1:0]   occ_q, occ_d;
    logic         pop_ok, push_ok;

    // Next entry contents and occupancy from push/pop
    always_comb begin
        e0_d    = e0_q;
        e1_d    = e1_q;
        occ_d   = occ_q;
        pop_ok  = pop && (occ_q != 2'd0);
        push_ok = push && ((occ_q != 2'd2) || pop_ok);
        case (occ_q)
            2'd0: begin
                if (push_ok) begin
                    e0_d  = push_data;
                    occ_d = 2'd1;
                end
            end
            2'd1: begin
                if (push_ok && pop_ok) begin
                    e0_d = push_data;
                end else if (push_ok) begin
                    e1_d  = push_data;
                    occ_d = 2'd2;
                end else if (pop_ok) begin
                    occ_d = 2'd0;
                end
            end
            2'd2: begin
                if (pop_ok) begin
                    e0_d = e1_q;
                    if (push_ok) e1_d = push_data;
                    else         occ_d = 2'd1;
                end
            end
            default: occ_d = 2'd0;
        endcase
    end

    // Entry and occupancy registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e0_q  <= '0;
            e1_q  <= '0;
            occ_q <= 2'd0;
        end else begin
            e0_q  <= e0_d;
            e1_q  <= e1_d;
            occ_q <= occ_d;
        end
    end

    assign head  = e0_q;
    assign valid = (occ_q != 2'd0);
    assign occ   = occ_q;

endmodule

// File: rtl/mem_fetch_stream.sv
// Sequential port-B reader: walks Mem4K from a base address until the
// sentinel word and streams {address, word} pairs downstream.
//
//   state | meaning
//   IDLE  | after reset, waiting for start
//   FETCH | reading one word per cycle into the 2-entry buffer
//   DRAIN | reading stopped, waiting for the buffer to empty
//   DONE  | finished (err says why), waiting for the next start
module mem_fetch_stream
    import mem_fetch_stream_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [31:0]         base_addr,
    mem_fetch_stream_if.master  bus,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [15:0]         count
);

    state_t      state_q, state_d;
    logic [31:0] abus_q, abus_d;
    logic [15:0] count_q, count_d;
    logic        err_q, err_d;
    logic        errp_q, errp_d;

    logic        push, pop, can_accept, fifo_valid;
    logic [1:0]  occ;
    logic [63:0] head;

    assign pop        = fifo_valid && bus.o_ready;
    assign can_accept = (occ != 2'd2) || pop;

    // Next state, read address and status from FSM and buffer space
    always_comb begin
        state_d = state_q;
        abus_d  = abus_q;
        count_d = count_q;
        err_d   = err_q;
        errp_d  = errp_q;
        push    = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    count_d = 16'd0;
                    errp_d  = 1'b0;
                    if (base_ok(base_addr)) begin
                        state_d = S_FETCH;
                        abus_d  = base_addr;
                        err_d   = 1'b0;
                    end else begin
                        state_d = S_DONE;
                        err_d   = 1'b1;
                    end
                end
            end
            S_FETCH: begin
                if (can_accept) begin
                    if (bus.B_DBusR == SENTINEL) begin
                        state_d = S_DRAIN;
                    end else begin
                        push = 1'b1;
                        if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
                        if ((abus_q + 32'd4) < ADDR_LIMIT) begin
                            abus_d = abus_q + 32'd4;
                        end else begin
                            state_d = S_DRAIN;
                            errp_d  = 1'b1;
                        end
                    end
                end
            end
            S_DRAIN: begin
                if (occ == 2'd0) begin
                    state_d = S_DONE;
                    err_d   = errp_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            abus_q  <= 32'd0;
            count_q <= 16'd0;
            err_q   <= 1'b0;
            errp_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            abus_q  <= abus_d;
            count_q <= count_d;
            err_q   <= err_d;
            errp_q  <= errp_d;
        end
    end

    fetch_skid2 #(.W(64)) u_skid (
        .clk       (clk),
        .rst_n     (rst),
        .push      (push),
        .push_data ({abus_q, bus.B_DBusR}),
        .pop       (pop),
        .head      (head),
        .valid     (fifo_valid),
        .occ       (occ)
    );

    assign bus.B_EnWR  = MM_ENB_R;
    assign bus.B_Size  = MW_Word;
    assign bus.B_DBusW = 32'b0;
    assign bus.B_ABus  = abus_q;
    assign bus.o_valid = fifo_valid;
    assign bus.o_data  = head[31:0];
    assign bus.o_addr  = head[63:32];

    assign busy  = (state_q == S_FETCH) || (state_q == S_DRAIN);
    assign done  = (state_q == S_DONE);
    assign err   = err_q;
    assign count = count_q;

endmodule

// File: tb/tb_mem_fetch_stream.sv
// Directed bench for mem_fetch_stream: a vector table of fetch scenarios
// plus hand-written reset-during-fetch and startup sequences.
module tb_mem_fetch_stream;
    import mem_fetch_stream_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] base_addr = 32'd0;
    logic        busy, done, err;
    logic [15:0] count;

    logic [31:0] mem [0:1023];

    mem_fetch_stream_if bus ();

    assign bus.B_DBusR = mem[bus.B_ABus[11:2]];

    mem_fetch_stream dut (
        .clk       (clk),
        .rst       (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .bus       (bus),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .count     (count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        int               img;
        logic [31:0]      base;
        int               stall;
        bit               mid_start;
        int               n;
        logic [0:3][31:0] ea;
        logic [0:3][31:0] ed;
        logic             eerr;
        int               ecnt;
        int               ecyc;
        logic [31:0]      emax;
    } vec_t;

    localparam int NV = 6;
    vec_t vecs [NV];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_img(input int img);
        for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
        if (img == 0) begin
            mem[512] = 32'h11;
            mem[513] = 32'h22;
            mem[514] = 32'h33;
            mem[515] = 32'h0000FFFF;
        end else begin
            mem[1022] = 32'hA1;
            mem[1023] = 32'hA2;
        end
    endtask

    task automatic set_vec(input int i, input int img, input logic [31:0] base,
                           input int stall, input bit mid, input int n,
                           input logic [0:3][31:0] ea, input logic [0:3][31:0] ed,
                           input logic eerr, input int ecnt, input int ecyc,
                           input logic [31:0] emax);
        vecs[i].img = img;   vecs[i].base = base;   vecs[i].stall = stall;
        vecs[i].mid_start = mid; vecs[i].n = n;     vecs[i].ea = ea;
        vecs[i].ed = ed;     vecs[i].eerr = eerr;   vecs[i].ecnt = ecnt;
        vecs[i].ecyc = ecyc; vecs[i].emax = emax;
    endtask

    task automatic run_case(input int idx);
        vec_t        v;
        int          n, cyc, first_valid, stall_cnt;
        bit          sent;
        logic [31:0] maxab;
        logic [31:0] got_a [8];
        logic [31:0] got_d [8];
        int          got_c [8];
        v = vecs[idx];
        load_img(v.img);
        bus.o_ready = (v.stall == 0);
        n = 0; first_valid = -1; stall_cnt = 0; sent = 0; maxab = 32'd0;
        start = 1'b1;
        base_addr = v.base;
        tick();
        start = 1'b0;
        cyc = 1;
        chk($sformatf("v%0d_lat_novalid", idx), {31'd0, bus.o_valid}, 32'd0);
        if (v.n > 0) chk($sformatf("v%0d_lat_abus", idx), bus.B_ABus, v.base);
        while (!done && cyc < 100) begin
            if (busy && bus.B_ABus > maxab) maxab = bus.B_ABus;
            if (bus.o_valid && first_valid < 0) begin
                first_valid = cyc;
                chk($sformatf("v%0d_first_valid_cyc", idx), first_valid, 32'd2);
            end
            start = (v.mid_start && cyc == 3);
            base_addr = start ? 32'd0 : v.base;
            if (v.stall > 0 && bus.o_valid && !bus.o_ready) begin
                stall_cnt++;
                chk($sformatf("v%0d_stall_data", idx), bus.o_data, v.ed[0]);
                if (stall_cnt >= 3) chk($sformatf("v%0d_stall_abus", idx), bus.B_ABus, v.ea[2]);
                if (stall_cnt >= v.stall) bus.o_ready = 1'b1;
            end
            if (bus.o_valid && bus.o_data == SENTINEL) sent = 1'b1;
            if (bus.o_valid && bus.o_ready && n < 8) begin
                got_a[n] = bus.o_addr;
                got_d[n] = bus.o_data;
                got_c[n] = cyc;
                n++;
            end
            tick();
            cyc++;
        end
        start = 1'b0;
        chk($sformatf("v%0d_done", idx), {31'd0, done}, 32'd1);
        chk($sformatf("v%0d_err", idx), {31'd0, err}, {31'd0, v.eerr});
        chk($sformatf("v%0d_count", idx), {16'd0, count}, v.ecnt);
        chk($sformatf("v%0d_nwords", idx), n, v.n);
        chk($sformatf("v%0d_sentinel_fwd", idx), {31'd0, sent}, 32'd0);
        if (v.n == 0) chk($sformatf("v%0d_never_valid", idx), first_valid, -1);
        for (int k = 0; k < n && k < 4 && k < v.n; k++) begin
            chk($sformatf("v%0d_addr%0d", idx, k), got_a[k], v.ea[k]);
            chk($sformatf("v%0d_data%0d", idx, k), got_d[k], v.ed[k]);
            if (v.stall == 0) chk($sformatf("v%0d_consec%0d", idx, k), got_c[k], got_c[0] + k);
        end
        if (v.ecyc != 0) chk($sformatf("v%0d_done_cyc", idx), cyc, v.ecyc);
        if (v.emax != 0) chk($sformatf("v%0d_max_abus", idx), maxab, v.emax);
        tick();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_abus"},  bus.B_ABus, 32'd0);
        chk({tag, "_valid"}, {31'd0, bus.o_valid}, 32'd0);
        chk({tag, "_odata"}, bus.o_data, 32'd0);
        chk({tag, "_oaddr"}, bus.o_addr, 32'd0);
        chk({tag, "_busy"},  {31'd0, busy}, 32'd0);
        chk({tag, "_done"},  {31'd0, done}, 32'd0);
        chk({tag, "_err"},   {31'd0, err}, 32'd0);
        chk({tag, "_count"}, {16'd0, count}, 32'd0);
    endtask

    initial begin
        bus.o_ready = 1'b1;
        set_vec(0, 0, 32'd2048, 0, 1'b0, 3, {32'd2048, 32'd2052, 32'd2056, 32'd0},
                {32'h11, 32'h22, 32'h33, 32'h0}, 1'b0, 3, 6, 32'd2060);
        set_vec(1, 0, 32'd4096, 0, 1'b0, 0, '0, '0, 1'b1, 0, 1, 32'd0);
        set_vec(2, 0, 32'd2048, 5, 1'b0, 3, {32'd2048, 32'd2052, 32'd2056, 32'd0},
                {32'h11, 32'h22, 32'h33, 32'h0}, 1'b0, 3, 0, 32'd2060);
        set_vec(3, 0, 32'd2050, 0, 1'b0, 0, '0, '0, 1'b1, 0, 1, 32'd0);
        set_vec(4, 1, 32'd4088, 0, 1'b0, 2, {32'd4088, 32'd4092, 32'd0, 32'd0},
                {32'hA1, 32'hA2, 32'h0, 32'h0}, 1'b1, 2, 5, 32'd4092);
        set_vec(5, 0, 32'd2048, 0, 1'b1, 3, {32'd2048, 32'd2052, 32'd2056, 32'd0},
                {32'h11, 32'h22, 32'h33, 32'h0}, 1'b0, 3, 6, 32'd2060);

        #2;
        chk_reset_outputs("por");
        tick();
        rst_n = 1'b1;
        tick();
        chk("const_enwr",  {31'd0, bus.B_EnWR}, {31'd0, MM_ENB_R});
        chk("const_size",  {30'd0, bus.B_Size}, {30'd0, MW_Word});
        chk("const_dbusw", bus.B_DBusW, 32'd0);

        for (int i = 0; i < NV; i++) run_case(i);

        // reset in the middle of a fetch, then the same fetch again
        load_img(0);
        bus.o_ready = 1'b1;
        start = 1'b1;
        base_addr = 32'd2048;
        tick();
        start = 1'b0;
        tick();
        chk("pre_rst_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        tick();
        rst_n = 1'b1;
        tick();
        run_case(0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
